// File: rtl/microseq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : microseq_pkg                                                  |
// | Purpose  : Shared types and constants for the microsequencer: the ALU    |
// |            opcode and FSM state enums, the instruction field positions   |
// |            and the packed 19-bit instruction word layout.                |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package microseq_pkg;

  localparam int c_data_w   = 8;
  localparam int c_nregs    = 8;

  // Bit positions of the instruction fields
  localparam int c_op_hi     = 18;
  localparam int c_op_lo     = 16;
  localparam int c_wr_en_bit = 15;
  localparam int c_rd_hi     = 14;
  localparam int c_rd_lo     = 12;
  localparam int c_ra_hi     = 11;
  localparam int c_ra_lo     = 9;
  localparam int c_use_imm   = 8;
  localparam int c_imm_hi    = 7;
  localparam int c_imm_lo    = 0;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SHL  = 3'd1,
    OP_SHR  = 3'd2,
    OP_AND  = 3'd3,
    OP_OR   = 3'd4,
    OP_XOR  = 3'd5,
    OP_NOT  = 3'd6,
    OP_HALT = 3'd7
  } op_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EXEC  = 3'd2,
    WB    = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Field order matches the bit positions above, MSB first.
  // When use_imm is clear, imm[2:0] carries the rb register index.
  typedef struct packed {
    op_t        op;
    logic       wr_en;
    logic [2:0] rd;
    logic [2:0] ra;
    logic       use_imm;
    logic [7:0] imm;
  } instr_t;

endpackage
`default_nettype wire

// File: rtl/microseq_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : microseq_if                                                   |
// | Purpose  : Bundle of the sequencer's control, ROM and debug signals.     |
// |   master : executor side - drives rom_addr, busy, done, err, flags and   |
// |            dbg_data; receives start, rom_data and dbg_sel.               |
// |   slave  : environment side - the mirror image.                          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface microseq_if #(
  parameter int ADDR_W = 6,
  parameter int IW     = 19
);
  logic              start;
  logic [ADDR_W-1:0] rom_addr;
  logic [IW-1:0]     rom_data;
  logic              busy;
  logic              done;
  logic              err;
  logic              zero_flag;
  logic              carry_flag;
  logic [2:0]        dbg_sel;
  logic [7:0]        dbg_data;

  modport master (
    input  start, rom_data, dbg_sel,
    output rom_addr, busy, done, err, zero_flag, carry_flag, dbg_data
  );

  modport slave (
    output start, rom_data, dbg_sel,
    input  rom_addr, busy, done, err, zero_flag, carry_flag, dbg_data
  );
endinterface
`default_nettype wire

// File: rtl/microseq_alu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : microseq_alu                                                  |
// | Purpose  : Combinational 8-bit ALU for the microsequencer.               |
// | Ports    : op   in  opcode (HALT yields 0)                               |
// |            a,b  in  8-bit operands                                       |
// |            y    out 8-bit result                                         |
// |            cout out carry out of ADD, 0 for every other op               |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module microseq_alu
  import microseq_pkg::*;
(
  input  op_t        op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] y,
  output logic       cout
);

  logic [8:0] w_sum;
  logic       w_shift_ovf;

  // Carry-in is always zero.
  assign w_sum = {1'b0, a} + {1'b0, b};

  // Shift amount is the full 8-bit B: anything of 8 or more clears the result.
  assign w_shift_ovf = |b[7:3];

  always_comb begin
    y    = '0;
    cout = 1'b0;
    case (op)
      OP_ADD: begin
        y    = w_sum[7:0];
        cout = w_sum[8];
      end
      OP_SHL:  y = w_shift_ovf ? 8'h00 : (a << b[2:0]);
      OP_SHR:  y = w_shift_ovf ? 8'h00 : (a >> b[2:0]);
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NOT:  y = ~a;
      default: y = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/microseq_exec.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : microseq_exec                                                 |
// | Purpose  : Fetches 19-bit microinstructions from a combinational ROM,    |
// |            executes them on an 8 x 8-bit register file and writes back.  |
// |            Each non-HALT instruction takes FETCH, EXEC, WB; a run ends   |
// |            on HALT or after STEP_LIMIT instructions (with err set).      |
// | Ports    : clock  in  rising-edge clock                                  |
// |            reset  in  asynchronous active-low reset                      |
// |            bus    master modport: start, rom_addr/rom_data, busy, done,  |
// |                   err, zero_flag, carry_flag, dbg_sel/dbg_data           |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module microseq_exec
  import microseq_pkg::*;
#(
  parameter int ADDR_W     = 6,
  parameter int IW         = 19,
  parameter int STEP_LIMIT = 64
) (
  input  logic       clock,
  input  logic       reset,
  microseq_if.master bus
);

  localparam int c_sc_w = $clog2(STEP_LIMIT + 1);

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_pc;
  instr_t            r_ir;
  logic [c_sc_w-1:0] r_steps;
  logic [7:0]        r_result;
  logic              r_err;
  logic              r_zero;
  logic              r_carry;
  logic [7:0]        r_regs [c_nregs];

  logic [IW-1:0]     w_rom_word;
  logic [7:0]        w_op_a;
  logic [7:0]        w_op_b;
  logic [7:0]        w_alu_y;
  logic              w_alu_cout;
  logic              w_step_last;
  logic              w_busy;
  logic              w_done;

  assign w_rom_word = bus.rom_data;

  // Operands are read from the register file during EXEC, so an instruction
  // whose rd matches ra or rb sees the old value.
  assign w_op_a = r_regs[r_ir.ra];
  assign w_op_b = r_ir.use_imm ? r_ir.imm : r_regs[r_ir.imm[2:0]];

  // The WB that completes this step is the STEP_LIMIT-th one.
  assign w_step_last = (r_steps == c_sc_w'(STEP_LIMIT - 1));

  microseq_alu u_alu (
    .op   (r_ir.op),
    .a    (w_op_a),
    .b    (w_op_b),
    .y    (w_alu_y),
    .cout (w_alu_cout)
  );

  // Next-state and status decode
  always_comb begin
    w_state_next = r_state;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) w_state_next = FETCH;
      end
      FETCH: begin
        w_busy       = 1'b1;
        w_state_next = EXEC;
      end
      EXEC: begin
        w_busy       = 1'b1;
        w_state_next = (r_ir.op == OP_HALT) ? DONE : WB;
      end
      WB: begin
        w_busy       = 1'b1;
        w_state_next = w_step_last ? DONE : FETCH;
      end
      DONE: begin
        w_done       = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_pc     <= '0;
      r_ir     <= '0;
      r_steps  <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
      r_zero   <= 1'b0;
      r_carry  <= 1'b0;
      for (int i = 0; i < c_nregs; i++) r_regs[i] <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_pc    <= '0;
            r_steps <= '0;
            r_err   <= 1'b0;
          end
        end
        FETCH: r_ir <= instr_t'(w_rom_word);
        EXEC: begin
          // HALT leaves flags and the result register untouched.
          if (r_ir.op != OP_HALT) begin
            r_result <= w_alu_y;
            r_zero   <= (w_alu_y == 8'h00);
            r_carry  <= w_alu_cout;
          end
        end
        WB: begin
          if (r_ir.wr_en) r_regs[r_ir.rd] <= r_result;
          r_pc    <= r_pc + 1'b1;
          r_steps <= r_steps + 1'b1;
          if (w_step_last) r_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.rom_addr   = r_pc;
  assign bus.busy       = w_busy;
  assign bus.done       = w_done;
  assign bus.err        = r_err;
  assign bus.zero_flag  = r_zero;
  assign bus.carry_flag = r_carry;
  assign bus.dbg_data   = r_regs[bus.dbg_sel];

endmodule
`default_nettype wire

// File: tb/tb_microseq_exec.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_microseq_exec                                              |
// | Purpose  : Directed self-checking bench for microseq_exec; the ROM is a  |
// |            bench-side array read combinationally through the interface.  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_microseq_exec;

  localparam logic [2:0] ADD = 3'd0, SHL = 3'd1, SHR = 3'd2, AND_ = 3'd3,
                         OR_ = 3'd4, XOR_ = 3'd5, NOT_ = 3'd6, HALT = 3'd7;

  logic clock;
  logic reset;
  logic [18:0] rom [64];
  logic [7:0]  exp_regs [8];
  int errors = 0;
  int checks = 0;

  microseq_if #(.ADDR_W(6), .IW(19)) bus ();

  microseq_exec #(.ADDR_W(6), .IW(19), .STEP_LIMIT(64)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.rom_data = rom[bus.rom_addr];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [18:0] enc(input logic [2:0] op, input logic wr,
                                      input logic [2:0] rd, input logic [2:0] ra,
                                      input logic ui, input logic [7:0] imm);
    return {op, wr, rd, ra, ui, imm};
  endfunction

  task automatic fill_rom(input logic [18:0] w);
    for (int i = 0; i < 64; i++) rom[i] = w;
  endtask

  task automatic read_reg(input int idx, output logic [7:0] v);
    bus.dbg_sel = idx[2:0];
    #1;
    v = bus.dbg_data;
  endtask

  // Pulse start, then count negedges (FETCH of the first word is 1) until done.
  task automatic run_prog(input int limit, output int n);
    @(negedge clock); bus.start = 1'b1;
    @(negedge clock); bus.start = 1'b0;
    n = 1;
    while (bus.done !== 1'b1 && n < limit) begin
      @(negedge clock);
      n++;
    end
  endtask

  task automatic test_reset;
    logic [7:0] v;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bus.err); end
    checks++; if (bus.zero_flag !== 1'b0) begin errors++; $display("FAIL reset_zero: got %b want 0", bus.zero_flag); end
    checks++; if (bus.carry_flag !== 1'b0) begin errors++; $display("FAIL reset_carry: got %b want 0", bus.carry_flag); end
    checks++; if (bus.rom_addr !== 6'd0) begin errors++; $display("FAIL reset_pc: got %0d want 0", bus.rom_addr); end
    for (int i = 0; i < 8; i++) begin
      read_reg(i, v);
      checks++; if (v !== 8'h00) begin errors++; $display("FAIL reset_r%0d: got %h want 00", i, v); end
    end
  endtask

  task automatic test_halt;
    logic [7:0] v;
    fill_rom(enc(HALT, 1'b0, 3'd0, 3'd0, 1'b0, 8'h00));
    @(negedge clock); bus.start = 1'b1;
    @(negedge clock); bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin errors++; $display("FAIL halt_c1: got busy=%b done=%b want 1 0", bus.busy, bus.done); end
    @(negedge clock);
    checks++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin errors++; $display("FAIL halt_c2: got busy=%b done=%b want 1 0", bus.busy, bus.done); end
    @(negedge clock);
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b1) begin errors++; $display("FAIL halt_c3: got busy=%b done=%b want 0 1", bus.busy, bus.done); end
    checks++; if (bus.rom_addr !== 6'd0) begin errors++; $display("FAIL halt_pc: got %0d want 0", bus.rom_addr); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL halt_err: got %b want 0", bus.err); end
    @(negedge clock);
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL halt_c4: got busy=%b done=%b want 0 0", bus.busy, bus.done); end
    for (int i = 0; i < 8; i++) begin
      read_reg(i, v);
      checks++; if (v !== 8'h00) begin errors++; $display("FAIL halt_r%0d: got %h want 00", i, v); end
    end
  endtask

  task automatic test_imm_add;
    int n;
    logic [7:0] v;
    fill_rom(enc(HALT, 1'b0, 3'd0, 3'd0, 1'b0, 8'h00));
    rom[0] = enc(ADD, 1'b1, 3'd1, 3'd0, 1'b1, 8'hFF);
    rom[1] = enc(ADD, 1'b1, 3'd2, 3'd1, 1'b1, 8'h01);
    run_prog(100, n);
    checks++; if (n !== 9) begin errors++; $display("FAIL add_cycles: got %0d want 9", n); end
    read_reg(1, v);
    checks++; if (v !== 8'hFF) begin errors++; $display("FAIL add_r1: got %h want ff", v); end
    read_reg(2, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL add_r2: got %h want 00", v); end
    checks++; if (bus.carry_flag !== 1'b1) begin errors++; $display("FAIL add_carry: got %b want 1", bus.carry_flag); end
    checks++; if (bus.zero_flag !== 1'b1) begin errors++; $display("FAIL add_zero: got %b want 1", bus.zero_flag); end
    checks++; if (bus.rom_addr !== 6'd2) begin errors++; $display("FAIL add_pc: got %0d want 2", bus.rom_addr); end
  endtask

  task automatic test_reg_ops;
    int n;
    logic [7:0] v;
    fill_rom(enc(HALT, 1'b0, 3'd0, 3'd0, 1'b0, 8'h00));
    rom[0] = enc(ADD,  1'b1, 3'd1, 3'd0, 1'b1, 8'hA5);
    rom[1] = enc(ADD,  1'b1, 3'd2, 3'd0, 1'b1, 8'h0F);
    rom[2] = enc(AND_, 1'b1, 3'd3, 3'd1, 1'b0, 8'h02);
    rom[3] = enc(XOR_, 1'b1, 3'd4, 3'd1, 1'b0, 8'h02);
    rom[4] = enc(NOT_, 1'b1, 3'd5, 3'd1, 1'b1, 8'h33);
    rom[5] = enc(SHL,  1'b1, 3'd6, 3'd1, 1'b1, 8'h03);
    rom[6] = enc(SHR,  1'b1, 3'd7, 3'd1, 1'b1, 8'h09);
    rom[7] = enc(ADD,  1'b1, 3'd2, 3'd2, 1'b0, 8'h02);  // r2 = r2 + r2
    run_prog(100, n);
    checks++; if (n !== 27) begin errors++; $display("FAIL ops_cycles: got %0d want 27", n); end
    exp_regs = '{8'h00, 8'hA5, 8'h1E, 8'h05, 8'hAA, 8'h5A, 8'h28, 8'h00};
    for (int i = 0; i < 8; i++) begin
      read_reg(i, v);
      checks++; if (v !== exp_regs[i]) begin errors++; $display("FAIL ops_r%0d: got %h want %h", i, v, exp_regs[i]); end
    end
    checks++; if (bus.zero_flag !== 1'b0 || bus.carry_flag !== 1'b0) begin errors++; $display("FAIL ops_flags: got z=%b c=%b want 0 0", bus.zero_flag, bus.carry_flag); end
  endtask

  task automatic test_no_write;
    int n;
    logic [7:0] v;
    fill_rom(enc(HALT, 1'b0, 3'd0, 3'd0, 1'b0, 8'h00));
    rom[0] = enc(ADD,  1'b0, 3'd0, 3'd1, 1'b1, 8'h80);  // A5+80 carries, not written
    rom[1] = enc(XOR_, 1'b0, 3'd1, 3'd1, 1'b0, 8'h01);  // r1^r1 = 0, not written
    rom[2] = enc(HALT, 1'b0, 3'd0, 3'd0, 1'b0, 8'h00);
    run_prog(100, n);
    checks++; if (n !== 9) begin errors++; $display("FAIL nowr_cycles: got %0d want 9", n); end
    checks++; if (bus.zero_flag !== 1'b1) begin errors++; $display("FAIL nowr_zero: got %b want 1", bus.zero_flag); end
    checks++; if (bus.carry_flag !== 1'b0) begin errors++; $display("FAIL nowr_carry: got %b want 0", bus.carry_flag); end
    for (int i = 0; i < 8; i++) begin
      read_reg(i, v);
      checks++; if (v !== exp_regs[i]) begin errors++; $display("FAIL nowr_r%0d: got %h want %h", i, v, exp_regs[i]); end
    end
  endtask

  task automatic test_step_limit;
    int n;
    logic [5:0] pc63;
    fill_rom(enc(ADD, 1'b0, 3'd0, 3'd0, 1'b1, 8'h01));
    pc63 = 6'd0;
    @(negedge clock); bus.start = 1'b1;
    @(negedge clock); bus.start = 1'b0;
    n = 1;
    while (bus.done !== 1'b1 && n < 400) begin
      @(negedge clock);
      n++;
      bus.start = (n == 50);  // a start while busy must be ignored
      if (n == 190) pc63 = bus.rom_addr;
    end
    bus.start = 1'b0;
    checks++; if (n !== 193) begin errors++; $display("FAIL limit_cycles: got %0d want 193", n); end
    checks++; if (pc63 !== 6'd63) begin errors++; $display("FAIL limit_pc63: got %0d want 63", pc63); end
    checks++; if (bus.rom_addr !== 6'd0) begin errors++; $display("FAIL limit_wrap: got %0d want 0", bus.rom_addr); end
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL limit_err: got %b want 1", bus.err); end
    @(negedge clock);
    checks++; if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL limit_hold: got err=%b busy=%b want 1 0", bus.err, bus.busy); end
    // Second start clears err
    rom[0] = enc(HALT, 1'b0, 3'd0, 3'd0, 1'b0, 8'h00);
    @(negedge clock); bus.start = 1'b1;
    @(negedge clock); bus.start = 1'b0;
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL limit_errclr: got %b want 0", bus.err); end
    n = 1;
    while (bus.done !== 1'b1 && n < 100) begin
      @(negedge clock);
      n++;
    end
    checks++; if (n !== 3 || bus.err !== 1'b0) begin errors++; $display("FAIL limit_rerun: got n=%0d err=%b want 3 0", n, bus.err); end
  endtask

  task automatic test_reset_midrun;
    logic [7:0] v;
    fill_rom(enc(HALT, 1'b0, 3'd0, 3'd0, 1'b0, 8'h00));
    rom[0] = enc(ADD, 1'b1, 3'd3, 3'd0, 1'b1, 8'h77);
    @(negedge clock); bus.start = 1'b1;
    @(negedge clock); bus.start = 1'b0;   // FETCH
    @(negedge clock);                     // EXEC
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL mid_exec_busy: got %b want 1", bus.busy); end
    reset = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mid_async: got busy=%b want 0", bus.busy); end
    @(negedge clock); reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL mid_idle%0d: got busy=%b done=%b want 0 0", c, bus.busy, bus.done); end
    end
    read_reg(3, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL mid_r3: got %h want 00", v); end
    checks++; if (bus.rom_addr !== 6'd0) begin errors++; $display("FAIL mid_pc: got %0d want 0", bus.rom_addr); end
  endtask

  initial begin
    reset = 1'b0;
    bus.start = 1'b0;
    bus.dbg_sel = 3'd0;
    fill_rom(enc(HALT, 1'b0, 3'd0, 3'd0, 1'b0, 8'h00));
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    test_reset();
    test_halt();
    test_imm_add();
    test_reg_ops();
    test_no_write();
    test_step_limit();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
